inst_rom_banked: RTL

Banked, runtime-loadable instruction memory for the 9-bit core. It holds `NUM_PROG` independent program images, each of `2**ADDR_W` words. Images are written over a valid/ready load port, and the core fetches through a registered-read port. It sits between the fetch stage (`InstAddress` → `InstOut`) and the test/boot loader, so program images can be swapped without re-elaborating the design.

---
 rtl/inst_pkg.sv | 16 +
 rtl/inst_ram.sv | 34 +++
 rtl/inst_rom_banked.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/inst_pkg.sv
// Shared definitions for the banked instruction memory: NOP encoding,
// default instruction width and the load FSM state type.
package inst_pkg;

    localparam int INST_W_DEF = 9;

    localparam logic [INST_W_DEF-1:0] NOP = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } load_state_t;

endpackage

// File: rtl/inst_ram.sv
// Single-port synchronous RAM with registered read data. The array itself is
// never reset; only the read-data register is, so the fetch output starts at 0.
module inst_ram #(
    parameter int WIDTH     = 9,
    parameter int WORDS     = 384,
    parameter int ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data holds between reads so the fetch output keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/inst_rom_banked.sv
// Banked, runtime-loadable instruction memory: a load FSM writes program
// images over a valid/ready port while the core fetches through a 1-cycle read.
module inst_rom_banked
    import inst_pkg::*;
#(
    parameter int INST_W   = INST_W_DEF,
    parameter int ADDR_W   = 7,
    parameter int NUM_PROG = 3,
    localparam int SEL_W   = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              LoadStart,
    input  logic [SEL_W-1:0]  LoadBank,
    input  logic              LoadValid,
    input  logic [INST_W-1:0] LoadData,
    input  logic              LoadLast,
    output logic              LoadReady,
    output logic              LoadDone,
    input  logic [SEL_W-1:0]  ProgSel,
    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] InstAddress,
    output logic              InstValid,
    output logic [INST_W-1:0] InstOut,
    output logic              FetchErr,
    output logic              Busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int RAM_WORDS = NUM_PROG * DEPTH;
    localparam logic [SEL_W:0] NUM_PROG_W = NUM_PROG[SEL_W:0];
    localparam logic [INST_W-1:0] NOP_W = INST_W'(NOP);

    load_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] wptr_reg, wptr_next;
    logic [SEL_W-1:0]  bank_reg, bank_next;
    logic [NUM_PROG-1:0] bank_valid_reg;
    logic [NUM_PROG-1:0] clr_vec, set_vec;

    logic inst_valid_reg, fetch_err_reg, nop_sel_reg;

    logic load_sel_ok, prog_sel_ok, fetch_hit;
    logic start_ok, beat, served;

    logic                     ram_we, ram_re;
    logic [SEL_W+ADDR_W-1:0]  ram_addr;
    logic [INST_W-1:0]        ram_wdata, ram_rdata;

    assign load_sel_ok = ({1'b0, LoadBank} < NUM_PROG_W);
    assign prog_sel_ok = ({1'b0, ProgSel} < NUM_PROG_W);
    assign fetch_hit   = prog_sel_ok && bank_valid_reg[ProgSel];

    assign start_ok = (state_reg == IDLE) && LoadStart && load_sel_ok;
    assign beat     = (state_reg == LOAD) && LoadValid;
    assign served   = (state_reg == IDLE) && FetchReq;

    // The FSM keeps the single RAM port exclusive: writes only in LOAD/FILL,
    // reads only in IDLE.
    assign ram_we    = beat || (state_reg == FILL);
    assign ram_re    = served && fetch_hit;
    assign ram_wdata = beat ? LoadData : NOP_W;
    assign ram_addr  = ram_we ? {bank_reg, wptr_reg} : {ProgSel, InstAddress};

    inst_ram #(
        .WIDTH    (INST_W),
        .WORDS    (RAM_WORDS),
        .ADDR_BITS(SEL_W + ADDR_W)
    ) u_ram (
        .clk  (Clk),
        .rst_n(ResetN),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_reg <= IDLE;
            wptr_reg  <= '0;
            bank_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wptr_reg  <= wptr_next;
            bank_reg  <= bank_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wptr_next  = wptr_reg;
        bank_next  = bank_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next = LOAD;
                    bank_next  = LoadBank;
                    wptr_next  = '0;
                end
            end
            LOAD: begin
                if (beat) begin
                    if (wptr_reg == '1) begin
                        state_next = DONE;
                        wptr_next  = '0;
                    end else begin
                        wptr_next = wptr_reg + ADDR_W'(1);
                        if (LoadLast) begin
                            state_next = FILL;
                        end
                    end
                end
            end
            FILL: begin
                if (wptr_reg == '1) begin
                    state_next = DONE;
                    wptr_next  = '0;
                end else begin
                    wptr_next = wptr_reg + ADDR_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_PROG; gi++) begin : g_bank
        assign clr_vec[gi] = start_ok && (LoadBank == SEL_W'(gi));
        assign set_vec[gi] = (state_reg == DONE) && (bank_reg == SEL_W'(gi));
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            bank_valid_reg <= '0;
        end else begin
            bank_valid_reg <= (bank_valid_reg & ~clr_vec) | set_vec;
        end
    end

    // nop_sel_reg only moves on a served fetch so InstOut holds between fetches.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            inst_valid_reg <= 1'b0;
            fetch_err_reg  <= 1'b0;
            nop_sel_reg    <= 1'b0;
        end else begin
            inst_valid_reg <= served;
            fetch_err_reg  <= served && !fetch_hit;
            if (served) begin
                nop_sel_reg <= !fetch_hit;
            end
        end
    end

    assign InstValid = inst_valid_reg;
    assign FetchErr  = fetch_err_reg;
    assign InstOut   = nop_sel_reg ? NOP_W : ram_rdata;
    assign LoadReady = (state_reg == LOAD);
    assign LoadDone  = (state_reg == DONE);
    assign Busy      = (state_reg != IDLE);

endmodule
